keypad_matrix_emulator: RTL and testbench

//  Drives a 4x4 matrix keypad for test/bring-up. The scanner supplies active-low row drive;

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/kp_bounce_gen.sv | 75 +++++++
 rtl/keypad_matrix_emulator.sv | 151 +++++++++++++++
 tb/tb_keypad_matrix_emulator.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad types and helpers, used by the emulator and by the keypad scanner.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } kp_emu_state_t;

  localparam logic [3:0] NO_KEY_COLS = 4'hF;

  // Key codes are {row[1:0], col[1:0]}.
  function automatic logic [1:0] key_row(input logic [3:0] code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] code);
    return code[1:0];
  endfunction

endpackage

// File: rtl/kp_bounce_gen.sv
// Contact bounce generator, shared by the press and release bounce phases.
// level_o is the contact level for the coming cycle, so the parent can register
// it alongside its own state. done_o is high in the last cycle of the phase.
module kp_bounce_gen
  import keypad_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 20,
  parameter int unsigned BOUNCE_PERIOD = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic init_level_i,
  output logic level_o,
  output logic done_o
);

  // Guard against a zero-length bounce so the counters keep a legal width.
  localparam int unsigned PH_MAX = (BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES : 1;
  localparam int unsigned TG_MAX = (BOUNCE_PERIOD > 0) ? BOUNCE_PERIOD : 1;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned TG_W   = $clog2(TG_MAX + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PH_MAX - 1);
  localparam logic [TG_W-1:0] TG_LAST = TG_W'(TG_MAX - 1);

  logic [PH_W-1:0] phase_q, phase_d;
  logic [TG_W-1:0] tog_q, tog_d;
  logic            level_q, level_d;
  logic            active_q, active_d;

  assign done_o  = active_q && (phase_q == PH_LAST);
  assign level_o = level_d;

  // Next-state: restart on start, otherwise advance the phase and toggle the level.
  always_comb begin
    phase_d  = phase_q;
    tog_d    = tog_q;
    level_d  = level_q;
    active_d = active_q;
    if (start_i) begin
      phase_d  = '0;
      tog_d    = '0;
      level_d  = init_level_i;
      active_d = 1'b1;
    end else if (active_q) begin
      if (phase_q == PH_LAST) begin
        active_d = 1'b0;
      end else begin
        phase_d = phase_q + 1'b1;
        if (tog_q == TG_LAST) begin
          tog_d   = '0;
          level_d = ~level_q;
        end else begin
          tog_d = tog_q + 1'b1;
        end
      end
    end
  end

  // Counter and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      tog_q    <= '0;
      level_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      tog_q    <= tog_d;
      level_q  <= level_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Emulates one key of a 4x4 active-low matrix keypad: plays press-bounce, hold,
// release-bounce and an idle gap for each accepted key code.
//
// state      | meaning
// IDLE       | no key, ready for a command
// BOUNCE_IN  | press bounce, contact starts closed and toggles
// HOLD       | contact solidly closed
// BOUNCE_OUT | release bounce, contact starts open and toggles
// GAP        | contact open; last cycle pulses done and accepts the next command
module keypad_matrix_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 20,
  parameter int unsigned BOUNCE_PERIOD = 3,
  parameter int unsigned HOLD_CYCLES   = 400,
  parameter int unsigned GAP_CYCLES    = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows_in,
  output logic [3:0] cols_out,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_key,
  output logic       cmd_ready,
  output logic       busy,
  output logic       contact,
  output logic       done_pulse
);

  localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);
  localparam int unsigned MAX_A = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > BOUNCE_CYCLES) ? MAX_A : BOUNCE_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_P + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  kp_emu_state_t    state_q, state_d;
  logic [3:0]       key_q, key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             contact_q, contact_d;
  logic             accept;
  logic             bnc_start, bnc_init, bnc_level, bnc_done;

  kp_bounce_gen #(
    .BOUNCE_CYCLES (BOUNCE_CYCLES),
    .BOUNCE_PERIOD (BOUNCE_PERIOD)
  ) u_bounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (bnc_start),
    .init_level_i (bnc_init),
    .level_o      (bnc_level),
    .done_o       (bnc_done)
  );

  // Next-state logic; the GAP exit cycle already accepts so back-to-back keys lose no cycle.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    cnt_d      = cnt_q;
    cmd_ready  = 1'b0;
    done_pulse = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
      end
      BOUNCE_IN: begin
        if (bnc_done) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          if (HAS_BOUNCE) state_d = BOUNCE_OUT;
          else            state_d = GAP;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BOUNCE_OUT: begin
        if (bnc_done) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          done_pulse = 1'b1;
          cmd_ready  = 1'b1;
          accept     = cmd_valid;
          state_d    = IDLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (accept) begin
      key_d = cmd_key;
      cnt_d = '0;
      if (HAS_BOUNCE) state_d = BOUNCE_IN;
      else            state_d = HOLD;
    end
  end

  // Contact level for the next cycle follows the state being entered.
  always_comb begin
    bnc_start = ((state_d == BOUNCE_IN)  && (state_q != BOUNCE_IN)) ||
                ((state_d == BOUNCE_OUT) && (state_q != BOUNCE_OUT));
    bnc_init  = (state_d == BOUNCE_IN);
    case (state_d)
      BOUNCE_IN, BOUNCE_OUT: contact_d = bnc_level;
      HOLD:                  contact_d = 1'b1;
      default:               contact_d = 1'b0;
    endcase
  end

  // State, key and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      key_q     <= '0;
      cnt_q     <= '0;
      contact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      cnt_q     <= cnt_d;
      contact_q <= contact_d;
    end
  end

  // Switch model: the selected column follows its row line while the contact is closed.
  always_comb begin
    cols_out = NO_KEY_COLS;
    if (contact_q && (rows_in[key_row(key_q)] == 1'b0))
      cols_out[key_col(key_q)] = 1'b0;
  end

  assign busy    = (state_q != IDLE);
  assign contact = contact_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench: one instance without bounce, one with a short bounce.
module tb_keypad_matrix_emulator;

  logic       clk;
  logic       rst_n;
  logic [3:0] rows0, key0, cols0;
  logic       valid0, ready0, busy0, contact0, done0;
  logic [3:0] rows1, key1, cols1;
  logic       valid1, ready1, busy1, contact1, done1;
  int         total;
  int         passed;

  keypad_matrix_emulator #(
    .BOUNCE_CYCLES (0),
    .BOUNCE_PERIOD (1),
    .HOLD_CYCLES   (8),
    .GAP_CYCLES    (4)
  ) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rows_in    (rows0),
    .cols_out   (cols0),
    .cmd_valid  (valid0),
    .cmd_key    (key0),
    .cmd_ready  (ready0),
    .busy       (busy0),
    .contact    (contact0),
    .done_pulse (done0)
  );

  keypad_matrix_emulator #(
    .BOUNCE_CYCLES (6),
    .BOUNCE_PERIOD (2),
    .HOLD_CYCLES   (8),
    .GAP_CYCLES    (4)
  ) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rows_in    (rows1),
    .cols_out   (cols1),
    .cmd_valid  (valid1),
    .cmd_key    (key1),
    .cmd_ready  (ready1),
    .busy       (busy1),
    .contact    (contact1),
    .done_pulse (done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    rows0 = 4'b1110; key0 = 4'd0; valid0 = 1'b0;
    rows1 = 4'b0111; key1 = 4'd0; valid1 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (cols0 !== 4'hF) $display("FAIL reset_cols0 got %b exp 1111", cols0); else passed++;
    total++; if (ready0 !== 1'b1) $display("FAIL reset_ready0 got %b exp 1", ready0); else passed++;
    total++; if (busy0 !== 1'b0) $display("FAIL reset_busy0 got %b exp 0", busy0); else passed++;
    total++; if (contact0 !== 1'b0) $display("FAIL reset_contact0 got %b exp 0", contact0); else passed++;
    total++; if (done0 !== 1'b0) $display("FAIL reset_done0 got %b exp 0", done0); else passed++;
    total++; if (cols1 !== 4'hF) $display("FAIL reset_cols1 got %b exp 1111", cols1); else passed++;
    total++; if (busy1 !== 1'b0) $display("FAIL reset_busy1 got %b exp 0", busy1); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_rows();
    logic [3:0] rp [4];
    rp[0] = 4'b1110; rp[1] = 4'b1101; rp[2] = 4'b1011; rp[3] = 4'b0111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rows0 = rp[i % 4]; key0 = 4'($urandom_range(15, 0)); valid0 = 1'b0;
      #1;
      total++; if (cols0 !== 4'hF) $display("FAIL idle_cols i=%0d got %b exp 1111", i, cols0); else passed++;
      total++; if (ready0 !== 1'b1) $display("FAIL idle_ready i=%0d got %b exp 1", i, ready0); else passed++;
      total++; if (busy0 !== 1'b0) $display("FAIL idle_busy i=%0d got %b exp 0", i, busy0); else passed++;
    end
  endtask

  // Key 6 = row1/col2: rows 1101 -> cols 1011 during cycles 1..8, done at cycle 12.
  task automatic test_hold_basic();
    logic [3:0] ec;
    @(negedge clk);
    rows0 = 4'b1101; key0 = 4'd6; valid0 = 1'b1;
    #1;
    total++; if (ready0 !== 1'b1) $display("FAIL basic_accept_ready got %b exp 1", ready0); else passed++;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      valid0 = 1'b0; key0 = 4'd0;
      #1;
      ec = (k <= 8) ? 4'b1011 : 4'hF;
      total++; if (cols0 !== ec) $display("FAIL basic_cols k=%0d got %b exp %b", k, cols0, ec); else passed++;
      total++; if (done0 !== (k == 12)) $display("FAIL basic_done k=%0d got %b exp %b", k, done0, (k == 12)); else passed++;
      total++; if (busy0 !== (k <= 12)) $display("FAIL basic_busy k=%0d got %b exp %b", k, busy0, (k <= 12)); else passed++;
      total++; if (ready0 !== (k >= 12)) $display("FAIL basic_ready k=%0d got %b exp %b", k, ready0, (k >= 12)); else passed++;
    end
  endtask

  task automatic test_wrong_row();
    @(negedge clk);
    rows0 = 4'b1110; key0 = 4'd6; valid0 = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      valid0 = 1'b0;
      #1;
      total++; if (cols0 !== 4'hF) $display("FAIL wrongrow_cols k=%0d got %b exp 1111", k, cols0); else passed++;
      total++; if (contact0 !== (k <= 8)) $display("FAIL wrongrow_contact k=%0d got %b exp %b", k, contact0, (k <= 8)); else passed++;
    end
  endtask

  task automatic test_non_onehot();
    logic [3:0] rv;
    logic [3:0] ec;
    @(negedge clk);
    rows0 = 4'b1111; key0 = 4'd6; valid0 = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      valid0 = 1'b0;
      case (k)
        1:       rv = 4'b0000;
        2:       rv = 4'b1111;
        3:       rv = 4'b1001;
        4:       rv = 4'b0110;
        default: rv = 4'b0000;
      endcase
      rows0 = rv;
      #1;
      ec = ((k <= 8) && (k != 2) && (k != 4)) ? 4'b1011 : 4'hF;
      total++; if (cols0 !== ec) $display("FAIL nonhot_cols k=%0d rows=%b got %b exp %b", k, rv, cols0, ec); else passed++;
      total++; if (done0 !== (k == 12)) $display("FAIL nonhot_done k=%0d got %b exp %b", k, done0, (k == 12)); else passed++;
    end
  endtask

  // Key 15 with bounce 6 / period 2 on dut1: contact per cycle 1..24, LSB = cycle 1.
  task automatic test_bounce();
    logic [23:0] pat;
    logic        ek;
    logic [3:0]  ec;
    pat = 24'b0000_001100_11111111_110011;
    @(negedge clk);
    rows1 = 4'b0111; key1 = 4'd15; valid1 = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      valid1 = 1'b0;
      #1;
      ek = (k <= 24) ? pat[k-1] : 1'b0;
      ec = ek ? 4'b0111 : 4'hF;
      total++; if (contact1 !== ek) $display("FAIL bounce_contact k=%0d got %b exp %b", k, contact1, ek); else passed++;
      total++; if (cols1 !== ec) $display("FAIL bounce_cols k=%0d got %b exp %b", k, cols1, ec); else passed++;
      total++; if (done1 !== (k == 24)) $display("FAIL bounce_done k=%0d got %b exp %b", k, done1, (k == 24)); else passed++;
      total++; if (busy1 !== (k <= 24)) $display("FAIL bounce_busy k=%0d got %b exp %b", k, busy1, (k <= 24)); else passed++;
    end
  endtask

  task automatic test_busy_ignore();
    logic [3:0] ec;
    @(negedge clk);
    rows0 = 4'b1101; key0 = 4'd6; valid0 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      valid0 = (k == 4); key0 = (k == 4) ? 4'd9 : 4'd0;
      #1;
      ec = (k <= 8) ? 4'b1011 : 4'hF;
      if (k == 4) begin
        total++; if (ready0 !== 1'b0) $display("FAIL ignore_ready got %b exp 0", ready0); else passed++;
      end
      total++; if (cols0 !== ec) $display("FAIL ignore_cols k=%0d got %b exp %b", k, cols0, ec); else passed++;
      total++; if (done0 !== (k == 12)) $display("FAIL ignore_done k=%0d got %b exp %b", k, done0, (k == 12)); else passed++;
    end
    // Key 3 (row0/col3), then key 5 (row1/col1) held pending until done_pulse.
    @(negedge clk);
    rows0 = 4'b1110; key0 = 4'd3; valid0 = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k <= 12) begin
        valid0 = 1'b1; key0 = 4'd5;
      end else begin
        valid0 = 1'b0; key0 = 4'd0; rows0 = 4'b1101;
      end
      #1;
      if (k <= 12) ec = (k <= 8) ? 4'b0111 : 4'hF;
      else         ec = ((k - 12) <= 8) ? 4'b1101 : 4'hF;
      total++; if (cols0 !== ec) $display("FAIL b2b_cols k=%0d got %b exp %b", k, cols0, ec); else passed++;
      total++; if (done0 !== ((k == 12) || (k == 24))) $display("FAIL b2b_done k=%0d got %b exp %b", k, done0, ((k == 12) || (k == 24))); else passed++;
      total++; if (ready0 !== ((k == 12) || (k >= 24))) $display("FAIL b2b_ready k=%0d got %b exp %b", k, ready0, ((k == 12) || (k >= 24))); else passed++;
      total++; if (busy0 !== (k <= 24)) $display("FAIL b2b_busy k=%0d got %b exp %b", k, busy0, (k <= 24)); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ec;
    @(negedge clk);
    rows0 = 4'b1110; key0 = 4'd0; valid0 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      valid0 = 1'b0;
      #1;
      total++; if (cols0 !== 4'b1110) $display("FAIL rstmid_pre_cols k=%0d got %b exp 1110", k, cols0); else passed++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (cols0 !== 4'hF) $display("FAIL rstmid_cols got %b exp 1111", cols0); else passed++;
    total++; if (busy0 !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", busy0); else passed++;
    total++; if (contact0 !== 1'b0) $display("FAIL rstmid_contact got %b exp 0", contact0); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rows0 = 4'b1110; key0 = 4'd0; valid0 = 1'b1;
    #1;
    total++; if (ready0 !== 1'b1) $display("FAIL rstmid_ready got %b exp 1", ready0); else passed++;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      valid0 = 1'b0;
      #1;
      ec = (k <= 8) ? 4'b1110 : 4'hF;
      total++; if (cols0 !== ec) $display("FAIL rstmid_replay_cols k=%0d got %b exp %b", k, cols0, ec); else passed++;
      total++; if (done0 !== (k == 12)) $display("FAIL rstmid_replay_done k=%0d got %b exp %b", k, done0, (k == 12)); else passed++;
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_idle_rows();
    test_hold_basic();
    test_wrong_row();
    test_non_onehot();
    test_bounce();
    test_busy_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
